garage_door_input_conditioner: RTL
==================================

Name: garage_door_input_conditioner

Overview:
- Upstream front end of the garage door motor controller.
- Synchronises and debounces the raw remote button and both limit switches, and drives the controller's Active, UP_Max and DN_Max inputs.
- Generates Active as a run-request level: raised by a button press, held while the motor runs, dropped on arrival, stop-press, travel timeout or limit fault.
- Uses the controller's Up_Motor/Down_Motor outputs as feedback.

Parameters:
- DB_CYCLES, 16: consecutive stable synchronised cycles required before a debounced input changes (>=2).
- TIMEOUT_CYCLES, 1024: maximum RUN duration in cycles before a travel fault.
- REQ_WAIT, 4: cycles allowed in REQ for motor start.

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  reset, synchronous, active-low.
- Btn_Raw  in  1  raw asynchronous remote/wall button, 1 = pressed.
- Up_Lim_Raw  in  1  raw asynchronous top limit switch, 1 = door fully open.
- Dn_Lim_Raw  in  1  raw asynchronous bottom limit switch, 1 = door fully closed.
- Up_Motor  in  1  feedback from the motor controller.
- Down_Motor  in  1  feedback from the motor controller.
- Active  out  1  run request to the motor controller.
- UP_Max  out  1  debounced top limit.
- DN_Max  out  1  debounced bottom limit.
- Fault  out  1  sticky fault flag.

Behaviour:
- Reset: one clock, synchronous, active-low. While RST=0 at a rising edge, all sync flops, debounce counters and debounced values clear to 0, state = S_IDLE, watchdog = 0. Active, UP_Max, DN_Max and Fault all read 0. Reset mid-RUN drops Active on that edge.
- Synchroniser: 2-flop per raw input.
- Debounce, per input:
  - Counter clears whenever the sync output equals the debounced value.
  - On a mismatch the counter increments.
  - On a mismatch with counter = DB_CYCLES-1, the debounced value takes the sync value and the counter clears.
  - Latency: a clean raw edge first sampled at edge 1 appears on the debounced output after edge DB_CYCLES+2.
  - A glitch shorter than DB_CYCLES sync cycles never propagates.
- Outputs: UP_Max and DN_Max are the debounced limit registers, driven directly.
- Press pulse: one cycle, on a rising edge of the debounced button only. Holding the button yields one pulse.
- Limit fault: debounced up and down limits both 1 → S_FAULT from any state on the next edge.
- Watchdog: counts cycles in S_RUN and clears on every entry to S_RUN.
- State machine (registered; Active and Fault decoded from state):
  - S_IDLE (Active=0): press and no fault → S_REQ.
  - S_REQ (Active=1):
    - Up_Motor or Down_Motor = 1 → S_RUN.
    - Otherwise after REQ_WAIT cycles in REQ → S_IDLE. This covers a door stopped mid-travel, which the controller will not move.
    - Presses are ignored in REQ.
  - S_RUN (Active=1). Priority, highest first:
    1. Limit fault → S_FAULT.
    2. Watchdog = TIMEOUT_CYCLES-1 → S_FAULT.
    3. Press → S_IDLE (user stop; Active falls and the controller idles next edge).
    4. Up_Motor=0 and Down_Motor=0 → S_IDLE (arrival).
  - S_FAULT (Active=0, Fault=1): exits only on reset.
  - Unused encodings → S_IDLE.
- Both motor feedback bits at 1 are treated as running. No other checking is done on them.

Decomposition:
- Package garage_door_pkg holds the state encodings (S_IDLE, S_REQ, S_RUN, S_FAULT, 2 bits) and the default constants for DB_CYCLES, TIMEOUT_CYCLES and REQ_WAIT.
- One natural sub-module, input_debouncer: 2-flop synchroniser, counter and debounced register, parameterised by DB_CYCLES. It is instantiated three times.
- Counter widths are derived with $clog2.

Test Plan (DB_CYCLES=4, TIMEOUT_CYCLES=64, REQ_WAIT=4):
- Reset and debounce:
  - Stimulus: hold RST=0 for 3 cycles with all raw inputs 1. Release, then hold Dn_Lim_Raw=1, Up_Lim_Raw=0.
  - Response: all outputs 0 during reset. DN_Max=1 exactly 6 edges after release. Fault stays 0.
- Glitch rejection:
  - Stimulus: Btn_Raw pulsed for 3 cycles.
  - Response: no press pulse and Active stays 0. A 10-cycle pulse raises Active 7 edges after the first sampling edge.
- Open cycle:
  - Stimulus: DN_Max=1, then a press; a controller model raises Up_Motor 1 cycle after Active. Up_Lim_Raw rises 20 cycles later and the model drops Up_Motor.
  - Response: REQ→RUN. Active falls one edge after Up_Motor=0.
- Stop press:
  - Stimulus: second press during RUN.
  - Response: Active=0 on the edge after the press pulse. State returns to S_IDLE with Fault=0.
- Timeout:
  - Stimulus: motor held running and no limit change.
  - Response: Active drops and Fault=1 after 64 cycles in RUN. Further presses are ignored until RST=0.
- Limit fault and no-start:
  - Stimulus: both raw limits 1 during RUN.
  - Response: S_FAULT, Fault=1, Active=0.
  - Stimulus (separate run): press with the model never starting the motor.
  - Response: Active high for exactly 4 cycles, then 0.

Source files
------------

// File: rtl/garage_door_pkg.sv
// garage_door_pkg: state encoding and default timing constants shared by the
// garage door input conditioner and its debouncers.
package garage_door_pkg;
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_RUN   = 2'd2,
        S_FAULT = 2'd3
    } state_t;
    localparam int DB_CYCLES_DEF      = 16;
    localparam int TIMEOUT_CYCLES_DEF = 1024;
    localparam int REQ_WAIT_DEF       = 4;
endpackage

// File: rtl/input_debouncer.sv
// input_debouncer: 2-flop synchroniser followed by a debouncer that accepts a
// new level only after DB_CYCLES consecutive mismatching synchronised samples.
module input_debouncer
    import garage_door_pkg::*;
#(
    parameter int DB_CYCLES = DB_CYCLES_DEF
) (
    input  logic CLK,
    input  logic RST,
    input  logic raw,
    output logic deb
);
    localparam int CW = $clog2(DB_CYCLES);
    logic [1:0]    sync_q, sync_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          deb_q, deb_d;
    logic          expire;
    always_comb begin
        sync_d = {sync_q[0], raw};
        expire = (sync_q[1] != deb_q) && (cnt_q == CW'(DB_CYCLES - 1));
        cnt_d  = (sync_q[1] == deb_q || expire) ? '0 : cnt_q + 1'b1;
        deb_d  = expire ? sync_q[1] : deb_q;
    end
    always_ff @(posedge CLK) begin
        if (!RST) begin
            sync_q <= '0;
            cnt_q  <= '0;
            deb_q  <= 1'b0;
        end else begin
            sync_q <= sync_d;
            cnt_q  <= cnt_d;
            deb_q  <= deb_d;
        end
    end
    assign deb = deb_q;
endmodule

// File: rtl/garage_door_input_conditioner.sv
// garage_door_input_conditioner: conditions the button and limit switches and
// turns button presses plus motor feedback into the Active run-request level.
module garage_door_input_conditioner
    import garage_door_pkg::*;
#(
    parameter int DB_CYCLES      = DB_CYCLES_DEF,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
    parameter int REQ_WAIT       = REQ_WAIT_DEF
) (
    input  logic CLK,
    input  logic RST,
    input  logic Btn_Raw,
    input  logic Up_Lim_Raw,
    input  logic Dn_Lim_Raw,
    input  logic Up_Motor,
    input  logic Down_Motor,
    output logic Active,
    output logic UP_Max,
    output logic DN_Max,
    output logic Fault
);
    localparam int WW = $clog2(TIMEOUT_CYCLES);
    localparam int RW = $clog2(REQ_WAIT + 1);
    state_t        state_q, state_d;
    logic [WW-1:0] wd_q, wd_d;
    logic [RW-1:0] req_q, req_d;
    logic          btn_prev_q, btn_prev_d;
    logic          btn_deb, press, lim_fault, running;

    input_debouncer #(.DB_CYCLES(DB_CYCLES)) u_btn (.CLK(CLK), .RST(RST), .raw(Btn_Raw), .deb(btn_deb));
    input_debouncer #(.DB_CYCLES(DB_CYCLES)) u_up  (.CLK(CLK), .RST(RST), .raw(Up_Lim_Raw), .deb(UP_Max));
    input_debouncer #(.DB_CYCLES(DB_CYCLES)) u_dn  (.CLK(CLK), .RST(RST), .raw(Dn_Lim_Raw), .deb(DN_Max));

    always_comb begin
        btn_prev_d = btn_deb;
        press      = btn_deb && !btn_prev_q;
        lim_fault  = UP_Max && DN_Max;
        running    = Up_Motor || Down_Motor;
        wd_d       = (state_q == S_RUN) ? wd_q + 1'b1 : '0;
        req_d      = (state_q == S_REQ) ? req_q + 1'b1 : '0;
        state_d    = state_q;
        if (lim_fault) state_d = S_FAULT;
        else begin
            case (state_q)
                S_IDLE:  state_d = press ? S_REQ : S_IDLE;
                S_REQ:   state_d = running ? S_RUN : (req_q == RW'(REQ_WAIT - 1)) ? S_IDLE : S_REQ;
                // watchdog outranks a stop press, which outranks arrival
                S_RUN:   state_d = (wd_q == WW'(TIMEOUT_CYCLES - 1)) ? S_FAULT : (press || !running) ? S_IDLE : S_RUN;
                S_FAULT: state_d = S_FAULT;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q    <= S_IDLE;
            wd_q       <= '0;
            req_q      <= '0;
            btn_prev_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wd_q       <= wd_d;
            req_q      <= req_d;
            btn_prev_q <= btn_prev_d;
        end
    end

    assign Active = (state_q == S_REQ) || (state_q == S_RUN);
    assign Fault  = (state_q == S_FAULT);
endmodule
